// File: rtl/random_perm_pkg.sv
// Shared types, defaults and helper functions for the random permutation shuffler.
// The entropy option of lfsr_galois is selected with the RANDOM_PERM_ENTROPY_EN macro.
package random_perm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHUF = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;
  localparam logic [15:0] DEF_SEED      = 16'hACE1;

  localparam int MAX_ELEM_W = 6;
  localparam int MAX_TBL_W  = MAX_ELEM_W * (1 << MAX_ELEM_W);

  // Smallest 2**k-1 that covers i, used to draw swap candidates for index i.
  function automatic logic [MAX_ELEM_W-1:0] perm_mask(input logic [MAX_ELEM_W-1:0] i,
                                                      input int elem_w);
    logic [MAX_ELEM_W-1:0] m;
    m = '0;
    for (int k = 0; k < MAX_ELEM_W; k++) begin
      if (k < elem_w && m < i) m = {m[MAX_ELEM_W-2:0], 1'b1};
    end
    return m;
  endfunction

  // Packed identity table (entry k = k) for a table of 2**elem_w entries.
  function automatic logic [MAX_TBL_W-1:0] identity_table(input int elem_w);
    logic [MAX_TBL_W-1:0] t;
    t = '0;
    for (int k = 0; k < (1 << MAX_ELEM_W); k++) begin
      for (int b = 0; b < MAX_ELEM_W; b++) begin
        if (k < (1 << elem_w) && b < elem_w) t[k*elem_w + b] = k[b];
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/random_perm_shuffle_if.sv
// Request/status bundle between a sequence consumer and random_perm_shuffle.
// start/clear/seed_load are sampled on each rising clk edge and act only while
// state_dbg is IDLE; otherwise they are dropped (no queuing). done is a one-cycle pulse.
interface random_perm_shuffle_if #(
  parameter int ELEM_W = 4,
  parameter int LFSR_W = 16
);
  import random_perm_pkg::*;

  localparam int N = 1 << ELEM_W;

  logic                   start;
  logic                   clear;
  logic                   seed_load;
  logic [LFSR_W-1:0]      seed_in;
  logic [1:0]             ent_in;
  logic                   busy;
  logic                   done;
  logic [N*ELEM_W-1:0]    seq_all;
  state_t                 state_dbg;
  logic [LFSR_W-1:0]      lfsr_dbg;

  modport master (
    output start, clear, seed_load, seed_in, ent_in,
    input  busy, done, seq_all, state_dbg, lfsr_dbg
  );

  modport slave (
    input  start, clear, seed_load, seed_in, ent_in,
    output busy, done, seq_all, state_dbg, lfsr_dbg
  );

endinterface

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR with seed load; when RANDOM_PERM_ENTROPY_EN is defined
// the external entropy bits are folded into each step.
module lfsr_galois #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              adv,
  input  logic [1:0]        ent_in,
  output logic [LFSR_W-1:0] lfsr_q,
  output logic [LFSR_W-1:0] lfsr_d
);

  logic [LFSR_W-1:0] shifted;

  assign shifted = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);

`ifdef RANDOM_PERM_ENTROPY_EN
  logic [LFSR_W-1:0] mixed;
  assign mixed  = shifted ^ {{(LFSR_W-2){1'b0}}, ent_in};
  // An all-zero state would lock the LFSR up, so fall back to the seed.
  assign lfsr_d = (mixed == '0) ? SEED : mixed;
`else
  logic ent_unused;
  assign ent_unused = ^ent_in;
  assign lfsr_d     = shifted;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (load) begin
      lfsr_q <= (load_val == '0) ? SEED : load_val;
    end else if (adv) begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/random_perm_shuffle.sv
// Register table holding a permutation of 0..N-1, reshuffled in place by a
// rejection-sampled Fisher-Yates pass (one candidate per cycle).
module random_perm_shuffle
  import random_perm_pkg::*;
#(
  parameter int                ELEM_W    = 4,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(DEF_LFSR_TAPS),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEF_SEED)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  random_perm_shuffle_if.slave  bus
);

  localparam int N  = 1 << ELEM_W;
  localparam int TW = N * ELEM_W;
  localparam logic [MAX_TBL_W-1:0] IDENT_FULL = identity_table(ELEM_W);
  localparam logic [TW-1:0]        IDENT      = IDENT_FULL[TW-1:0];

  state_t                 state_q, state_d;
  logic [ELEM_W-1:0]      idx_q, idx_d;
  logic [TW-1:0]          tbl_q, tbl_d;
  logic [LFSR_W-1:0]      lfsr_q, lfsr_next;
  logic [MAX_ELEM_W-1:0]  idx_ext, mask_full;
  logic [ELEM_W-1:0]      mask_i, cand_j;
  logic                   take;
  logic                   lint_unused;

  lfsr_galois #(
    .LFSR_W    (LFSR_W),
    .LFSR_TAPS (LFSR_TAPS),
    .SEED      (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     ((state_q == IDLE) && bus.seed_load),
    .load_val (bus.seed_in),
    .adv      (state_q == SHUF),
    .ent_in   (bus.ent_in),
    .lfsr_q   (lfsr_q),
    .lfsr_d   (lfsr_next)
  );

  always_comb begin
    idx_ext = '0;
    idx_ext[ELEM_W-1:0] = idx_q;
  end

  // Candidate is drawn from the value the LFSR takes on this same edge.
  assign mask_full   = perm_mask(idx_ext, ELEM_W);
  assign mask_i      = mask_full[ELEM_W-1:0];
  assign cand_j      = lfsr_next[ELEM_W-1:0] & mask_i;
  assign take        = (cand_j <= idx_q);
  assign lint_unused = ^{mask_full, lfsr_next};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tbl_d   = tbl_q;
    case (state_q)
      IDLE: begin
        if (bus.clear) tbl_d = IDENT;
        if (bus.start) begin
          idx_d   = '1;
          state_d = SHUF;
        end
      end
      SHUF: begin
        if (take) begin
          tbl_d[ELEM_W*idx_q  +: ELEM_W] = tbl_q[ELEM_W*cand_j +: ELEM_W];
          tbl_d[ELEM_W*cand_j +: ELEM_W] = tbl_q[ELEM_W*idx_q  +: ELEM_W];
          idx_d = idx_q - 1'b1;
          if (idx_q == ELEM_W'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tbl_q   <= IDENT;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tbl_q   <= tbl_d;
    end
  end

  assign bus.busy      = (state_q == SHUF);
  assign bus.done      = (state_q == DONE);
  assign bus.seq_all   = tbl_q;
  assign bus.state_dbg = state_q;
  assign bus.lfsr_dbg  = lfsr_q;

endmodule

// File: tb/tb_random_perm_shuffle.sv
// Scoreboard bench: a 16-entry instance traced cycle by cycle against a Fisher-Yates
// reference model, and an 8-entry instance run through 1000 back-to-back shuffles.
module tb_random_perm_shuffle;
  import random_perm_pkg::*;

  localparam logic [15:0] TAPS = 16'hB400;
  localparam logic [15:0] SEED = 16'hACE1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a_n, rst_b_n;

  random_perm_shuffle_if #(.ELEM_W(4), .LFSR_W(16)) if_a ();
  random_perm_shuffle_if #(.ELEM_W(3), .LFSR_W(16)) if_b ();

  random_perm_shuffle #(.ELEM_W(4), .LFSR_W(16), .LFSR_TAPS(TAPS), .SEED(SEED)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .bus(if_a.slave));
  random_perm_shuffle #(.ELEM_W(3), .LFSR_W(16), .LFSR_TAPS(TAPS), .SEED(SEED)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .bus(if_b.slave));

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passes = 0;
  logic [64:0] exp_q[$];    // {done, packed table} per busy/done cycle of instance A
  logic [63:0] exp_b_q[$];  // final packed table per shuffle of instance B
  int done_cnt[2];
  int busy_run;
  logic [63:0] last_final[2];
  bit seen_b[8][8];

  // reference model: per-instance table and LFSR
  int m_tbl[2][64];
  logic [15:0] m_lfsr[2];
  int m_steps;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int n_of(input int inst);
    return (inst == 0) ? 16 : 8;
  endfunction

  function automatic int ew_of(input int inst);
    return (inst == 0) ? 4 : 3;
  endfunction

  function automatic logic [63:0] pack_m(input int inst);
    logic [63:0] v = '0;
    for (int k = 0; k < n_of(inst); k++) v |= 64'(m_tbl[inst][k]) << (k * ew_of(inst));
    return v;
  endfunction

  function automatic bit is_perm(input logic [63:0] v, input int n, input int ew);
    bit seen[64];
    for (int k = 0; k < 64; k++) seen[k] = 0;
    for (int k = 0; k < n; k++) seen[int'((v >> (k * ew)) & 64'((1 << ew) - 1))] = 1;
    for (int k = 0; k < n; k++) if (!seen[k]) return 0;
    return 1;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 16'h0);
  endfunction

  task automatic model_clear(input int inst);
    for (int k = 0; k < 64; k++) m_tbl[inst][k] = k;
  endtask

  // Fisher-Yates from the top index down, drawing j with a power-of-two mask and
  // redrawing whenever j exceeds i.
  task automatic model_shuffle(input int inst);
    int n, i, j, m, tmp;
    n = n_of(inst);
    i = n - 1;
    m_steps = 0;
    while (i >= 1) begin
      if (inst == 0) exp_q.push_back({1'b0, pack_m(0)});
      m_steps++;
      m_lfsr[inst] = lfsr_step(m_lfsr[inst]);
      m = 0;
      while (m < i) m = 2 * m + 1;
      j = (int'(m_lfsr[inst]) % n) & m;
      if (j <= i) begin
        tmp = m_tbl[inst][i];
        m_tbl[inst][i] = m_tbl[inst][j];
        m_tbl[inst][j] = tmp;
        i--;
      end
    end
    if (inst == 0) exp_q.push_back({1'b1, pack_m(0)});
    else exp_b_q.push_back(pack_m(1));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int inst, input logic st, input logic cl, input logic sl,
                       input logic [15:0] seed);
    @(posedge clk);
    #1;
    if (inst == 0) begin
      if_a.start = st; if_a.clear = cl; if_a.seed_load = sl; if_a.seed_in = seed;
    end else begin
      if_b.start = st; if_b.clear = cl; if_b.seed_load = sl; if_b.seed_in = seed;
    end
    if (sl) m_lfsr[inst] = (seed == 16'h0) ? SEED : seed;
    if (cl) model_clear(inst);
    if (st) model_shuffle(inst);
    @(posedge clk);
    #1;
    if (inst == 0) begin
      if_a.start = 0; if_a.clear = 0; if_a.seed_load = 0;
    end else begin
      if_b.start = 0; if_b.clear = 0; if_b.seed_load = 0;
    end
  endtask

  task automatic wait_done(input int inst, input int budget);
    int c0;
    bit ok;
    c0 = done_cnt[inst];
    ok = 0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clk);
      if (done_cnt[inst] != c0) ok = 1;
    end
    check(inst == 0 ? "a_done_within_budget" : "b_done_within_budget", 65'(ok), 65'd1);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_a_n === 1'b1 && (if_a.busy || if_a.done)) begin
      if (if_a.busy) busy_run++;
      if (if_a.done) begin
        done_cnt[0]++;
        last_final[0] = 64'(if_a.seq_all);
        check("a_final_is_perm", 65'(is_perm(64'(if_a.seq_all), 16, 4)), 65'd1);
      end
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL a_unexpected_activity: busy=%b done=%b seq=%h with no expectation",
                 if_a.busy, if_a.done, if_a.seq_all);
      end else begin
        check("a_trace", {if_a.done, 64'(if_a.seq_all)}, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b_n === 1'b1 && if_b.done) begin
      done_cnt[1]++;
      check("b_final_is_perm", 65'(is_perm(64'(if_b.seq_all), 8, 3)), 65'd1);
      for (int p = 0; p < 8; p++) seen_b[p][int'((if_b.seq_all >> (3 * p)) & 24'h7)] = 1;
      if (exp_b_q.size() == 0) begin
        checks++;
        $display("FAIL b_unexpected_done: seq=%h with no expectation", if_b.seq_all);
      end else begin
        check("b_final", 65'(if_b.seq_all), 65'(exp_b_q.pop_front()));
      end
    end
  end

  initial begin
    if_a.ent_in = 2'b00;
    if_b.ent_in = 2'b00;
    forever begin
      @(posedge clk);
      #2;
      if_a.ent_in = 2'($urandom);
      if_b.ent_in = 2'($urandom);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    bit all_seen;
    logic [63:0] first_model;
    if_a.start = 0; if_a.clear = 0; if_a.seed_load = 0; if_a.seed_in = '0;
    if_b.start = 0; if_b.clear = 0; if_b.seed_load = 0; if_b.seed_in = '0;
    done_cnt[0] = 0; done_cnt[1] = 0; busy_run = 0;
    for (int p = 0; p < 8; p++) for (int v = 0; v < 8; v++) seen_b[p][v] = 0;
    model_clear(0); model_clear(1);
    m_lfsr[0] = SEED; m_lfsr[1] = SEED;
    rst_a_n = 0; rst_b_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_seq_all", 65'(if_a.seq_all), 65'(pack_m(0)));
    check("reset_busy", 65'(if_a.busy), 65'd0);
    check("reset_done", 65'(if_a.done), 65'd0);
    check("reset_lfsr", 65'(if_a.lfsr_dbg), 65'(SEED));
    check("reset_state", 65'(if_a.state_dbg), 65'(IDLE));
    check("reset_b_seq_all", 65'(if_b.seq_all), 65'(pack_m(1)));
    rst_a_n = 1; rst_b_n = 1;

    // single shuffle from the reset seed
    busy_run = 0;
    drive(0, 1, 0, 0, 16'h0);
    first_model = pack_m(0);
    wait_done(0, 300);
    check("a_busy_cycles", 65'(busy_run), 65'(m_steps));
    check("a_busy_at_least_15", 65'(busy_run >= 15), 65'd1);
    check("a_lfsr_holds_idle", 65'(if_a.lfsr_dbg), 65'(m_lfsr[0]));

    // zero seed substitutes the default seed
    drive(0, 0, 1, 1, 16'h0);
    check("a_zero_seed_lfsr", 65'(if_a.lfsr_dbg), 65'(SEED));
    check("a_clear_identity", 65'(if_a.seq_all), 65'(pack_m(0)));
    drive(0, 1, 0, 0, 16'h0);
    wait_done(0, 300);
    check("a_zero_seed_same_result", 65'(last_final[0]), 65'(first_model));

    // start pulsed during SHUF is ignored
    d0 = done_cnt[0];
    drive(0, 1, 0, 0, 16'h0);
    repeat (3) @(posedge clk);
    #1 if_a.start = 1;
    @(posedge clk);
    #1 if_a.start = 0;
    wait_done(0, 300);
    repeat (30) @(posedge clk);
    check("a_single_done", 65'(done_cnt[0] - d0), 65'd1);
    check("a_queue_drained", 65'(exp_q.size()), 65'd0);

    // clear+start together starts from identity
    drive(0, 1, 1, 0, 16'h0);
    wait_done(0, 300);

    // randomized seeds, clears and composed shuffles
    for (int r = 0; r < 8; r++) begin
      drive(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
      wait_done(0, 300);
    end

    // reset asserted after the 5th SHUF cycle discards the shuffle
    drive(0, 1, 0, 0, 16'h0);
    repeat (5) @(posedge clk);
    #1 rst_a_n = 0;
    #1;
    exp_q.delete();
    model_clear(0);
    m_lfsr[0] = SEED;
    check("midrst_seq_identity", 65'(if_a.seq_all), 65'(pack_m(0)));
    check("midrst_busy", 65'(if_a.busy), 65'd0);
    check("midrst_state", 65'(if_a.state_dbg), 65'(IDLE));
    check("midrst_lfsr", 65'(if_a.lfsr_dbg), 65'(SEED));
    d0 = done_cnt[0];
    repeat (2) @(posedge clk);
    #1 rst_a_n = 1;
    repeat (40) @(posedge clk);
    check("midrst_no_done", 65'(done_cnt[0] - d0), 65'd0);

    // 8-entry instance: 1000 back-to-back shuffles
    for (int r = 0; r < 1000; r++) begin
      drive(1, 1, 0, 0, 16'h0);
      wait_done(1, 200);
    end
    repeat (5) @(posedge clk);
    for (int p = 0; p < 8; p++) begin
      all_seen = 1;
      for (int v = 0; v < 8; v++) if (!seen_b[p][v]) all_seen = 0;
      check($sformatf("b_pos%0d_all_values", p), 65'(all_seen), 65'd1);
    end
    check("b_queue_drained", 65'(exp_b_q.size()), 65'd0);
    check("a_queue_empty_end", 65'(exp_q.size()), 65'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/random_perm_shuffle.md
# random_perm_shuffle

Parametrised, clocked successor to the fixed 16-entry permutation network: holds a permutation of 0..N-1 (N = 2**ELEM_W) in a register table and reshuffles it on request with an in-place Fisher–Yates pass driven by an internal Galois LFSR. It sits between the sequence consumer (display and game logic reading `seq_all`) and the entropy source (rotary/button jitter on `ent_in`). It replaces the four hard-wired seed maps with a uniform, seedable, any-power-of-two-size shuffle.

## Interface
- `ELEM_W`, 4, element width; N = 2**ELEM_W entries (legal 2..6)
- `LFSR_W`, 16, LFSR width (legal 8..32, ≥ ELEM_W)
- `LFSR_TAPS`, 16'hB400, Galois feedback mask (maximal-length for LFSR_W)
- `SEED`, 16'hACE1, LFSR reset value and substitute for a zero seed; nonzero
- `clk` in 1: the single clock; all state on rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `start` in 1: request a shuffle; accepted only in IDLE
- `clear` in 1: reload the identity permutation; accepted only in IDLE
- `seed_load` in 1: load `seed_in` into the LFSR; accepted only in IDLE
- `seed_in` in LFSR_W: seed value
- `ent_in` in 2: external entropy bits
- `busy` out 1: shuffle in progress
- `done` out 1: one-cycle pulse on shuffle completion
- `seq_all` out N*ELEM_W: table; entry k at [ELEM_W*k +: ELEM_W]

## Operation
- Reset: table = identity (entry k = k), LFSR = SEED, state IDLE, `busy`=0, `done`=0.
- States: IDLE, SHUF, DONE.
- IDLE, same-cycle priority: `seed_load` (zero `seed_in` loads SEED), then `clear`, then `start`. `clear` and `start` together: identity first, then shuffle starts from identity. `seed_load` and `start` together: the shuffle uses the new seed.
- `start` in IDLE: index i = N-1, go to SHUF. The shuffle permutes the current table, not identity, so back-to-back shuffles compose.
- SHUF, every cycle:
  - LFSR advances one step (Galois shift right; XOR `LFSR_TAPS` when the shifted-out bit is 1).
  - Candidate j = lfsr_next[ELEM_W-1:0] & mask(i), where mask(i) = smallest 2**k-1 ≥ i.
  - j ≤ i: swap entries i and j (j = i is a legal no-op) and decrement i. If i was 1, go to DONE.
  - j > i: reject, i held, no swap.
- DONE: `done`=1 for one cycle, then IDLE.
- LFSR holds in IDLE and DONE. `start`, `clear` and `seed_load` are ignored outside IDLE, with no queuing.
- Invariant: `seq_all` is always a permutation of 0..N-1, including mid-shuffle.
- Reset asserted mid-shuffle: immediate return to the reset values; the partial shuffle is discarded.

## Timing
- `busy` is high from the cycle after `start` is accepted through the last SHUF cycle. It is low in DONE.
- Minimum shuffle latency: N-1 SHUF cycles, plus 1 DONE cycle. Each rejection adds 1 cycle. Rejection probability per cycle is < 1/2.
- `seq_all` is registered and updates on the same edge as each swap. It is final when `done` is high.
- A new `start` is accepted no earlier than the cycle after DONE (the first IDLE cycle).

## Configuration
- `RANDOM_PERM_ENTROPY_EN` defined:
  - Each SHUF step XORs `ent_in` into LFSR bits [1:0] after the shift.
  - A zero result is replaced by SEED.
  - Sequences become non-reproducible.
- Not defined: `ent_in` is ignored, and the output sequence is a pure function of seed, start history and table state. This is the mode the test bench compares against its model.

## Structure
- Package `random_perm_pkg`:
  - state enum (IDLE/SHUF/DONE)
  - default `LFSR_TAPS` and `SEED` constants
  - function `perm_mask(i, ELEM_W)`
  - function `identity_table(ELEM_W)`
- Sub-module `lfsr_galois`, parameters `LFSR_W` and `LFSR_TAPS`; ports: load, load value, advance enable, entropy input, state output.
- Top holds the FSM, index counter and table with its swap logic.

## Test plan
- Reset → `seq_all` = {15,14,…,1,0} packed (entry k = k), `busy`=0, `done`=0, LFSR = 16'hACE1.
- Entropy macro off, default seed, one `start` → `busy` high for ≥15 cycles. `seq_all` matches the reference model's swap-by-swap trace. `done` pulses exactly once. The final table contains each of 0..15 exactly once.
- `seed_load` with `seed_in`=0, then `start` → result identical to the run from reset seed 16'hACE1.
- `start` pulsed during SHUF → ignored (single `done`, table matches the single-shuffle model). `clear`+`start` together in IDLE → shuffle begins from identity.
- `rst_n` asserted after the 5th SHUF cycle → on the same edge, table = identity, `busy`=0, and no `done` follows.
- ELEM_W=3 instance, 1000 back-to-back shuffles → every result is a valid permutation of 0..7, and every position sees all 8 values.
